// File: rtl/byte_strip_param_if.sv
// Symbol-side and lane-side signal bundle for byte_strip_param.
// The master drives symbols in and observes lane groups; the slave is the striper.
interface byte_strip_param_if #(
  parameter int LANES = 4,
  parameter int BITS  = 8
);
  logic [BITS-1:0]       D;
  logic                  DK;
  logic                  VALID_IN;
  logic                  FLUSH;
  logic [1:0]            MODE;
  logic [LANES*BITS-1:0] LANE_OUT;
  logic [LANES-1:0]      DK_OUT;
  logic                  VALID_OUT;
  logic                  BUSY;

  modport master (
    output D, DK, VALID_IN, FLUSH, MODE,
    input  LANE_OUT, DK_OUT, VALID_OUT, BUSY
  );

  modport slave (
    input  D, DK, VALID_IN, FLUSH, MODE,
    output LANE_OUT, DK_OUT, VALID_OUT, BUSY
  );
endinterface

// File: rtl/byte_strip_param.sv
// Round-robin symbol striper: fills a staging group of ACT lanes, then emits it as one
// registered word with a one-cycle strobe. FLUSH closes a partial group with PAD_SYM.
module byte_strip_param #(
  parameter int              LANES   = 4,
  parameter int              BITS    = 8,
  parameter logic [BITS-1:0] PAD_SYM = 'hF7
) (
  input  logic                CLK,
  input  logic                RESET_L,
  byte_strip_param_if.slave   bus
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ACT_W = $clog2(LANES + 1);

  function automatic logic [ACT_W-1:0] mode_to_act(input logic [1:0] m);
    int unsigned n;
    n = 32'd1 << m;
    if (n > LANES) n = LANES;
    return ACT_W'(n);
  endfunction

  logic [ACT_W-1:0]      act_q, act_cur;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BITS-1:0]       stg_sym_q [LANES];
  logic [LANES-1:0]      stg_dk_q;
  logic [LANES*BITS-1:0] lane_q, grp_sym;
  logic [LANES-1:0]      dkout_q, grp_dk;
  logic                  vout_q, busy_q;
  logic                  last, emit;

  // Lane count only changes between groups, so the current MODE is used whenever
  // the group is empty and the latched count otherwise.
  always_comb begin
    act_cur = (idx_q == '0) ? mode_to_act(bus.MODE) : act_q;
    last    = (int'(idx_q) == int'(act_cur) - 1);
    emit    = (bus.VALID_IN && last) || (bus.FLUSH && (bus.VALID_IN || idx_q != '0));
    idx_d   = idx_q;
    if (emit)
      idx_d = '0;
    else if (bus.VALID_IN)
      idx_d = idx_q + 1'b1;
  end

  // Outgoing group: held slots, then the symbol arriving this cycle, then padding.
  always_comb begin
    grp_sym = '0;
    grp_dk  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(act_cur)) begin
        if (i < int'(idx_q)) begin
          grp_sym[i*BITS +: BITS] = stg_sym_q[i];
          grp_dk[i]               = stg_dk_q[i];
        end else if (i == int'(idx_q) && bus.VALID_IN) begin
          grp_sym[i*BITS +: BITS] = bus.D;
          grp_dk[i]               = bus.DK;
        end else begin
          grp_sym[i*BITS +: BITS] = PAD_SYM;
          grp_dk[i]               = 1'b1;
        end
      end
    end
  end

  // Stage boundary: staging slots and fill index
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      act_q    <= ACT_W'(1);
      idx_q    <= '0;
      busy_q   <= 1'b0;
      stg_dk_q <= '0;
      for (int i = 0; i < LANES; i++) stg_sym_q[i] <= '0;
    end else begin
      act_q  <= act_cur;
      idx_q  <= idx_d;
      busy_q <= (idx_d != '0);
      if (bus.VALID_IN) begin
        for (int i = 0; i < LANES; i++) begin
          if (i == int'(idx_q)) begin
            stg_sym_q[i] <= bus.D;
            stg_dk_q[i]  <= bus.DK;
          end
        end
      end
    end
  end

  // Stage boundary: output register, loaded only when a group closes
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      lane_q  <= '0;
      dkout_q <= '0;
      vout_q  <= 1'b0;
    end else begin
      vout_q <= emit;
      if (emit) begin
        lane_q  <= grp_sym;
        dkout_q <= grp_dk;
      end
    end
  end

  assign bus.LANE_OUT  = lane_q;
  assign bus.DK_OUT    = dkout_q;
  assign bus.VALID_OUT = vout_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_byte_strip_param.sv
// Directed bench for byte_strip_param with 4 lanes of 8 bits.
module tb_byte_strip_param;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  byte_strip_param_if #(.LANES(4), .BITS(8)) bus();

  byte_strip_param #(.LANES(4), .BITS(8), .PAD_SYM(8'hF7)) dut (
    .CLK     (clk),
    .RESET_L (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [36:0] obs = {bus.VALID_OUT, bus.DK_OUT, bus.LANE_OUT};

  task automatic send(input logic [7:0] d, input logic dk, input logic v, input logic f);
    bus.D        = d;
    bus.DK       = dk;
    bus.VALID_IN = v;
    bus.FLUSH    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [36:0] exp;
    rst_n = 1'b0;
    bus.D = '0; bus.DK = 1'b0; bus.VALID_IN = 1'b0; bus.FLUSH = 1'b0; bus.MODE = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp); end
    checks++;
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    rst_n = 1'b1;
  endtask

  task automatic test_four_lane();
    logic [36:0] exp;
    logic [7:0]  syms [4];
    syms[0] = 8'h11; syms[1] = 8'h22; syms[2] = 8'h33; syms[3] = 8'h44;
    bus.MODE = 2'd2;
    for (int k = 0; k < 3; k++) begin
      send(syms[k], 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL four_lane_early k=%0d got=%b exp=0", k, bus.VALID_OUT); end
    end
    send(syms[3], 1'b0, 1'b1, 1'b0);
    exp = {1'b1, 4'b0000, 32'h44332211};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL four_lane_group got=%h exp=%h", obs, exp); end
    send(8'h00, 1'b0, 1'b0, 1'b0);
    exp = {1'b0, 4'b0000, 32'h44332211};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL four_lane_hold got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp;
    logic [7:0]  s;
    bus.MODE = 2'd1;
    for (int k = 0; k < 6; k++) begin
      s = 8'hA0 + 8'(k);
      send(s, 1'b0, 1'b1, 1'b0);
      if (k % 2 == 1) begin
        exp = {1'b1, 4'b0000, 16'h0000, s, s - 8'h01};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL two_lane_group k=%0d got=%h exp=%h", k, obs, exp); end
      end else begin
        checks++;
        if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL two_lane_gap k=%0d got=%b exp=0", k, bus.VALID_OUT); end
      end
    end
    send(8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL two_lane_idle got=%b exp=0", bus.VALID_OUT); end
  endtask

  task automatic test_flush_pad();
    logic [36:0] exp;
    bus.MODE = 2'd2;
    send(8'hBC, 1'b1, 1'b1, 1'b0);
    send(8'h55, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL flush_busy_before got=%b exp=1", bus.BUSY); end
    send(8'h00, 1'b0, 1'b0, 1'b1);
    exp = {1'b1, 4'b1101, 32'hF7F755BC};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_pad_group got=%h exp=%h", obs, exp); end
    checks++;
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL flush_busy_after got=%b exp=0", bus.BUSY); end
    send(8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL flush_empty_noop got=%b exp=0", bus.VALID_OUT); end
  endtask

  task automatic test_flush_with_valid();
    logic [36:0] exp;
    bus.MODE = 2'd2;
    send(8'h01, 1'b0, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b1, 1'b0);
    send(8'h03, 1'b0, 1'b1, 1'b0);
    send(8'h99, 1'b0, 1'b1, 1'b1);
    exp = {1'b1, 4'b0000, 32'h99030201};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_valid_group got=%h exp=%h", obs, exp); end
    send(8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL flush_valid_single got=%b exp=0", bus.VALID_OUT); end
  endtask

  task automatic test_mode_change();
    logic [36:0] exp;
    bus.MODE = 2'd2;
    send(8'h61, 1'b0, 1'b1, 1'b0);
    send(8'h62, 1'b0, 1'b1, 1'b0);
    bus.MODE = 2'd0;
    send(8'h63, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.VALID_OUT, bus.BUSY} !== 2'b01) begin errors++; $display("FAIL mode_ignored got=%b exp=01", {bus.VALID_OUT, bus.BUSY}); end
    send(8'h00, 1'b0, 1'b0, 1'b1);
    exp = {1'b1, 4'b1000, 32'hF7636261};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mode_flush_group got=%h exp=%h", obs, exp); end
    send(8'h7E, 1'b0, 1'b1, 1'b0);
    exp = {1'b1, 4'b0000, 32'h0000007E};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL one_lane_group got=%h exp=%h", obs, exp); end
    send(8'h5A, 1'b1, 1'b1, 1'b1);
    exp = {1'b1, 4'b0001, 32'h0000005A};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL one_lane_flush got=%h exp=%h", obs, exp); end
    send(8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL one_lane_idle got=%b exp=0", bus.VALID_OUT); end
  endtask

  task automatic test_clamp();
    logic [36:0] exp;
    bus.MODE = 2'd3;
    send(8'hD1, 1'b0, 1'b1, 1'b0);
    send(8'hD2, 1'b1, 1'b1, 1'b0);
    send(8'hD3, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL clamp_early got=%b exp=0", bus.VALID_OUT); end
    send(8'hD4, 1'b0, 1'b1, 1'b0);
    exp = {1'b1, 4'b0010, 32'hD4D3D2D1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL clamp_group got=%h exp=%h", obs, exp); end
    send(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [36:0] exp;
    bus.MODE = 2'd2;
    send(8'h81, 1'b0, 1'b1, 1'b0);
    send(8'h82, 1'b0, 1'b1, 1'b0);
    bus.VALID_IN = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL async_reset_outputs got=%h exp=%h", obs, exp); end
    checks++;
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", bus.BUSY); end
    rst_n = 1'b1;
    send(8'h91, 1'b0, 1'b1, 1'b0);
    send(8'h92, 1'b0, 1'b1, 1'b0);
    send(8'h93, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.VALID_OUT !== 1'b0) begin errors++; $display("FAIL reset_mid_early got=%b exp=0", bus.VALID_OUT); end
    send(8'h94, 1'b0, 1'b1, 1'b0);
    exp = {1'b1, 4'b0000, 32'h94939291};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_mid_group got=%h exp=%h", obs, exp); end
    send(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_four_lane();
    test_back_to_back();
    test_flush_pad();
    test_flush_with_valid();
    test_mode_change();
    test_clamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
